// File: rtl/out_port_fifo.sv
// Output-port controller: accepts CPU words over out_req/out_ack into a FIFO and
// drains them to a device over valid/ready. Optional OUT_PORT_STATS_EN enables sent_cnt.
module out_port_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             out_req,
  input  logic [WIDTH-1:0] out_data,
  output logic             out_ack,
  output logic             dev_valid,
  output logic [WIDTH-1:0] dev_data,
  input  logic             dev_ready,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic [15:0]      sent_cnt,
  output logic [1:0]       dbg_state
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              wr_en;
  logic              rd_en;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [WIDTH-1:0]  mem [DEPTH];

  // Handshakes: a CPU word is taken at the edge where state is S_IDLE, out_req=1 and
  // full=0; out_ack is high for the following cycle only. A device word moves at any
  // edge where dev_valid & dev_ready. Both sides may move at the same edge.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    case (state)
      S_IDLE: begin
        if (out_req && !full) begin
          wr_en     = 1'b1;
          state_nxt = S_ACK;
        end
      end
      S_ACK:   state_nxt = S_WAIT;
      S_WAIT:  if (!out_req) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign out_ack   = (state == S_ACK);
  assign dbg_state = state;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign dev_valid = ~empty;
  assign dev_data  = mem[rd_ptr];
  assign rd_en     = dev_valid & dev_ready;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  // Storage carries no reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= out_data;
  end

`ifdef OUT_PORT_STATS_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)     sent_cnt <= 16'h0000;
    else if (rd_en) sent_cnt <= sent_cnt + 16'h0001;
  end
`else
  assign sent_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_out_port_fifo.sv
// Directed bench for out_port_fifo: CPU-side driver tasks, device-side monitor and
// an expected-word queue checked in order against every device transfer.
module tb_out_port_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_b;
  logic             out_req;
  logic [WIDTH-1:0] out_data;
  logic             out_ack;
  logic             dev_valid;
  logic [WIDTH-1:0] dev_data;
  logic             dev_ready;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic [15:0]      sent_cnt;
  logic [1:0]       dbg_state;

  out_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_b(rst_b), .out_req(out_req), .out_data(out_data),
    .out_ack(out_ack), .dev_valid(dev_valid), .dev_data(dev_data),
    .dev_ready(dev_ready), .count(count), .full(full), .empty(empty),
    .sent_cnt(sent_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [WIDTH-1:0] exp_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;
  int ack_cnt   = 0;
  int rx_cnt    = 0;
  logic prev_ack = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // monitor: samples mid-cycle, a transfer is committed at the next rising edge
  always @(negedge clk) begin
    if (rst_b) begin
      if (out_ack) begin
        ack_cnt <= ack_cnt + 1;
        check("ack_one_cycle", {31'd0, prev_ack}, 32'd0);
      end
      if (dev_valid && dev_ready) begin
        rx_cnt <= rx_cnt + 1;
        if (exp_q.size() == 0) check("sb_unexpected_word", {16'd0, dev_data}, 32'hFFFF_FFFF);
        else                   check("dev_data_order", {16'd0, dev_data}, {16'd0, exp_q.pop_front()});
      end
    end
    prev_ack <= out_ack;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (out_ack) seen = 1'b1;
    end
    check(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic release_req();
    tick();
    out_req  = 1'b0;
    out_data = WIDTH'($urandom_range(0, 16'hFFFF));
    tick();
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    out_req  = 1'b1;
    out_data = d;
    exp_q.push_back(d);
    wait_ack("send_ack");
    release_req();
  endtask

  task automatic drain();
    bit done = 1'b0;
    dev_ready = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (empty) done = 1'b1;
    end
    check("drain_empty", {31'd0, done}, 32'd1);
    check("sb_leftover", exp_q.size(), 32'd0);
    tick();
  endtask

  initial begin
    int ack0;
    int rx0;
    rst_b     = 1'b0;
    out_req   = 1'b0;
    out_data  = '0;
    dev_ready = 1'b0;
    repeat (3) tick();
    check("rst_count", {{(32-CW){1'b0}}, count}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_ack", {31'd0, out_ack}, 32'd0);
    check("rst_dev_valid", {31'd0, dev_valid}, 32'd0);
    check("rst_sent_cnt", {16'd0, sent_cnt}, 32'd0);
    rst_b = 1'b1;
    tick();

    // T1 single word
    dev_ready = 1'b1;
    ack0 = ack_cnt;
    send(16'h1234);
    tick();
    check("t1_acks", ack_cnt - ack0, 32'd1);
    check("t1_empty", {31'd0, empty}, 32'd1);
    check("t1_count", {{(32-CW){1'b0}}, count}, 32'd0);

    // T2 backpressure
    dev_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(16'hA000 + 16'(i));
    check("t2_full", {31'd0, full}, 32'd1);
    check("t2_count", {{(32-CW){1'b0}}, count}, 32'd4);
    ack0 = ack_cnt;
    out_req  = 1'b1;
    out_data = 16'hA004;
    exp_q.push_back(16'hA004);
    repeat (4) tick();
    check("t2_stall_no_ack", ack_cnt - ack0, 32'd0);
    dev_ready = 1'b1;
    tick();
    dev_ready = 1'b0;
    wait_ack("t2_ack_after_pop");
    release_req();
    check("t2_count_refill", {{(32-CW){1'b0}}, count}, 32'd4);
    drain();

    // T3 ordering and pointer wrap with toggling ready
    rx0 = rx_cnt;
    dev_ready = 1'b0;
    fork
      for (int i = 1; i <= 10; i++) send(16'(i));
      repeat (70) begin
        tick();
        dev_ready = ~dev_ready;
      end
    join
    drain();
    check("t3_rx_count", rx_cnt - rx0, 32'd10);

    // T4 held request
    dev_ready = 1'b0;
    ack0 = ack_cnt;
    out_req  = 1'b1;
    out_data = 16'h55AA;
    exp_q.push_back(16'h55AA);
    repeat (8) tick();
    out_req = 1'b0;
    repeat (2) tick();
    check("t4_single_ack", ack_cnt - ack0, 32'd1);
    check("t4_count", {{(32-CW){1'b0}}, count}, 32'd1);

    // T5 simultaneous write and read at count=2
    send(16'hB001);
    check("t5_count_before", {{(32-CW){1'b0}}, count}, 32'd2);
    out_req   = 1'b1;
    out_data  = 16'hB002;
    dev_ready = 1'b1;
    exp_q.push_back(16'hB002);
    tick();
    dev_ready = 1'b0;
    @(negedge clk);
    check("t5_ack", {31'd0, out_ack}, 32'd1);
    check("t5_count_same", {{(32-CW){1'b0}}, count}, 32'd2);
    check("t5_head", {16'd0, dev_data}, 32'h0000_B001);
    release_req();
    drain();

    // T6 reset mid-operation
    dev_ready = 1'b0;
    for (int i = 1; i <= 3; i++) send(16'hC000 + 16'(i));
    check("t6_count_pre", {{(32-CW){1'b0}}, count}, 32'd3);
    rst_b = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t6_count", {{(32-CW){1'b0}}, count}, 32'd0);
    check("t6_empty", {31'd0, empty}, 32'd1);
    check("t6_dev_valid", {31'd0, dev_valid}, 32'd0);
    check("t6_ack", {31'd0, out_ack}, 32'd0);
    check("t6_sent_cnt_rst", {16'd0, sent_cnt}, 32'd0);
    tick();
    rst_b = 1'b1;
    tick();
    dev_ready = 1'b1;
    for (int i = 1; i <= 3; i++) send(16'hD000 + 16'(i));
    drain();
`ifdef OUT_PORT_STATS_EN
    check("t6_sent_cnt", {16'd0, sent_cnt}, 32'd3);
`else
    check("t6_sent_cnt", {16'd0, sent_cnt}, 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
